// File: rtl/pal_timing_sequencer.sv
`default_nettype none
// ============================================================================
// pal_timing_sequencer : PAL raster counters with registered sync/burst/active
//                        strobe decode, subcarrier phase and parity outputs.
// Revision: 1.0
// ============================================================================
module pal_timing_sequencer #(
  parameter int LINE_SAMPLES  = 4540,
  parameter int HSYNC_SAMPLES = 335,
  parameter int EQ_SAMPLES    = 167,
  parameter int BROAD_SAMPLES = 1935,
  parameter int BURST_START   = 397,
  parameter int BURST_SAMPLES = 160,
  parameter int ACTIVE_START  = 745,
  parameter int ACTIVE_END    = 4423,
  parameter int FIELD1_LINES  = 312,
  parameter int FIELD2_LINES  = 313,
  parameter int VBLANK_LINES  = 25
) (
  input  logic        phaseClock,
  input  logic        reset,
  input  logic        enable,
  output logic [3:0]  subcarrierPhase,
  output logic        blank,
  output logic        sync,
  output logic        burst,
  output logic        oddFrame,
  output logic        oddLine,
  output logic        active,
  output logic [12:0] hCount,
  output logic [9:0]  lineInField,
  output logic        fieldStart
);

  localparam logic [12:0] H_LAST        = 13'(LINE_SAMPLES - 1);
  localparam logic [12:0] H_HALF        = 13'(LINE_SAMPLES / 2);
  localparam logic [12:0] H_HSYNC_END   = 13'(HSYNC_SAMPLES);
  localparam logic [12:0] H_EQ_END      = 13'(EQ_SAMPLES);
  localparam logic [12:0] H_BROAD_END   = 13'(BROAD_SAMPLES);
  localparam logic [12:0] H_HALF_EQ_END = 13'(LINE_SAMPLES / 2 + EQ_SAMPLES);
  localparam logic [12:0] H_HALF_BR_END = 13'(LINE_SAMPLES / 2 + BROAD_SAMPLES);
  localparam logic [12:0] H_BURST_START = 13'(BURST_START);
  localparam logic [12:0] H_BURST_END   = 13'(BURST_START + BURST_SAMPLES);
  localparam logic [12:0] H_ACT_START   = 13'(ACTIVE_START);
  localparam logic [12:0] H_ACT_END     = 13'(ACTIVE_END);
  localparam logic [9:0]  L_F1_LAST     = 10'(FIELD1_LINES - 1);
  localparam logic [9:0]  L_F2_LAST     = 10'(FIELD2_LINES - 1);
  localparam logic [9:0]  L_VBLANK      = 10'(VBLANK_LINES);

  // Free-running raster state
  logic [12:0] h_q, h_d;
  logic [9:0]  line_q, line_d;
  logic [1:0]  field_q, field_d;
  logic [3:0]  phase_q, phase_d;

  // Registered outputs, one cycle behind the raster state
  logic [3:0]  phase_out_q, phase_out_d;
  logic        blank_q, blank_d;
  logic        sync_q, sync_d;
  logic        burst_q, burst_d;
  logic        odd_frame_q, odd_frame_d;
  logic        odd_line_q, odd_line_d;
  logic        active_q, active_d;
  logic [12:0] hcount_q, hcount_d;
  logic [9:0]  line_out_q, line_out_d;
  logic        field_start_q, field_start_d;

  logic [9:0]  line_last;
  logic        broad_line, eq_line, video_line;

  always_comb begin
    line_last = field_q[0] ? L_F2_LAST : L_F1_LAST;
    h_d       = h_q + 13'd1;
    line_d    = line_q;
    field_d   = field_q;
    phase_d   = phase_q + 4'd1;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (line_q == line_last) begin
        line_d  = '0;
        field_d = field_q + 2'd1;
      end else begin
        line_d = line_q + 10'd1;
      end
    end
  end

  always_comb begin
    broad_line = (line_q <= 10'd2);
    eq_line    = (line_q >= 10'd3) && (line_q <= 10'd4);
    video_line = (line_q >= L_VBLANK);
    sync_d     = 1'b0;
    if (broad_line) begin
      sync_d = (h_q < H_BROAD_END) || ((h_q >= H_HALF) && (h_q < H_HALF_BR_END));
    end else if (eq_line) begin
      sync_d = (h_q < H_EQ_END) || ((h_q >= H_HALF) && (h_q < H_HALF_EQ_END));
    end else begin
      sync_d = (h_q < H_HSYNC_END);
    end
    // sync wins over burst if the parameters make the windows overlap
    burst_d       = video_line && !sync_d && (h_q >= H_BURST_START) && (h_q < H_BURST_END);
    active_d      = video_line && (h_q >= H_ACT_START) && (h_q < H_ACT_END);
    blank_d       = !active_d;
    odd_frame_d   = ~field_q[1];
    odd_line_d    = ~line_q[1];
    field_start_d = (h_q == 13'd0) && (line_q == 10'd0);
    phase_out_d   = phase_q;
    hcount_d      = h_q;
    line_out_d    = line_q;
  end

  always_ff @(posedge phaseClock) begin
    if (reset) begin
      h_q           <= '0;
      line_q        <= '0;
      field_q       <= '0;
      phase_q       <= '0;
      phase_out_q   <= '0;
      blank_q       <= 1'b1;
      sync_q        <= 1'b0;
      burst_q       <= 1'b0;
      odd_frame_q   <= 1'b1;
      odd_line_q    <= 1'b1;
      active_q      <= 1'b0;
      hcount_q      <= '0;
      line_out_q    <= '0;
      field_start_q <= 1'b0;
    end else if (enable) begin
      h_q           <= h_d;
      line_q        <= line_d;
      field_q       <= field_d;
      phase_q       <= phase_d;
      phase_out_q   <= phase_out_d;
      blank_q       <= blank_d;
      sync_q        <= sync_d;
      burst_q       <= burst_d;
      odd_frame_q   <= odd_frame_d;
      odd_line_q    <= odd_line_d;
      active_q      <= active_d;
      hcount_q      <= hcount_d;
      line_out_q    <= line_out_d;
      field_start_q <= field_start_d;
    end
  end

  assign subcarrierPhase = phase_out_q;
  assign blank           = blank_q;
  assign sync            = sync_q;
  assign burst           = burst_q;
  assign oddFrame        = odd_frame_q;
  assign oddLine         = odd_line_q;
  assign active          = active_q;
  assign hCount          = hcount_q;
  assign lineInField     = line_out_q;
  assign fieldStart      = field_start_q;

endmodule
`default_nettype wire
